// File: rtl/data_mem_stage.sv
// Data-memory pipeline stage: byte-addressed load/store into a small word
// array, with a write-back handshake and a retire pulse per request.
module data_mem_stage #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_result,
    input  logic [XLEN-1:0] i_store_data,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic [2:0]      i_funct3,
    input  logic [4:0]      i_rd,
    output logic            o_wb_valid,
    input  logic            i_wb_ready,
    output logic [XLEN-1:0] o_wb_data,
    output logic [4:0]      o_wb_rd,
    output logic            o_flush,
    output logic            o_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = XLEN / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2, RETIRE = 2'd3} state_t;

    state_t          state_r, state_s;
    logic [XLEN-1:0] addr_r, sdata_r;
    logic            rd_en_r, wr_en_r;
    logic [2:0]      f3_r;
    logic [4:0]      rd_r;
    logic            ready_r, wb_valid_r, flush_r, err_r;
    logic [XLEN-1:0] wb_data_r;
    logic [4:0]      wb_rd_r;
    logic [XLEN-1:0] mem_r [DEPTH] = '{default: '0};

    logic            illegal_s, wb_need_s;
    logic [AW-1:0]   idx_s;
    logic [1:0]      off_s;
    logic [NB-1:0]   be_s;
    logic [XLEN-1:0] wdata_s;
    logic            unused_s;

    // Unsigned codes exist only for loads; stores with them are rejected.
    function automatic logic is_illegal(input logic rd, input logic wr,
                                        input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (rd && wr) begin
            bad = 1'b1;
        end else if (rd || wr) begin
            case (f3)
                3'b000:  bad = 1'b0;
                3'b001:  bad = off[0];
                3'b010:  bad = (off != 2'b00);
                3'b100:  bad = wr;
                3'b101:  bad = wr | off[0];
                default: bad = 1'b1;
            endcase
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                    input logic [1:0] off, input logic [2:0] f3);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] res;
        b = word[8*int'(off) +: 8];
        h = word[16*int'(off[1]) +: 16];
        case (f3)
            3'b000:  res = {{(XLEN-8){b[7]}}, b};
            3'b001:  res = {{(XLEN-16){h[15]}}, h};
            3'b100:  res = {{(XLEN-8){1'b0}}, b};
            3'b101:  res = {{(XLEN-16){1'b0}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Decode of the latched request: index, lane enables, legality, write-back need.
    always_comb begin
        idx_s     = addr_r[AW+1:2];
        off_s     = addr_r[1:0];
        illegal_s = is_illegal(rd_en_r, wr_en_r, f3_r, off_s);
        wb_need_s = !illegal_s && (rd_r != 5'd0) && (rd_en_r || (!wr_en_r && WB_BYPASS));
        unused_s  = &{1'b0, addr_r};
        be_s      = '0;
        for (int i = 0; i < NB; i++) begin
            case (f3_r)
                3'b000:  be_s[i] = ((i % 4) == int'(off_s));
                3'b001:  be_s[i] = (((i / 2) % 2) == int'(off_s[1]));
                3'b010:  be_s[i] = 1'b1;
                default: be_s[i] = 1'b0;
            endcase
        end
        case (f3_r)
            3'b000:  wdata_s = {NB{sdata_r[7:0]}};
            3'b001:  wdata_s = {(NB/2){sdata_r[15:0]}};
            default: wdata_s = sdata_r;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_valid) state_s = ACCESS;
                else         state_s = IDLE;
            end
            ACCESS: begin
                if (wb_need_s) state_s = RESP;
                else           state_s = RETIRE;
            end
            RESP: begin
                if (i_wb_ready) state_s = RETIRE;
                else            state_s = RESP;
            end
            RETIRE:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, request latch and registered outputs; outputs track the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ready_r    <= 1'b1;
            wb_valid_r <= 1'b0;
            flush_r    <= 1'b0;
            err_r      <= 1'b0;
            wb_data_r  <= '0;
            wb_rd_r    <= 5'd0;
            addr_r     <= '0;
            sdata_r    <= '0;
            rd_en_r    <= 1'b0;
            wr_en_r    <= 1'b0;
            f3_r       <= 3'd0;
            rd_r       <= 5'd0;
        end else begin
            state_r    <= state_s;
            ready_r    <= (state_s == IDLE);
            wb_valid_r <= (state_s == RESP);
            flush_r    <= (state_s == RETIRE);
            err_r      <= (state_s == RETIRE) && illegal_s;
            if (state_r == IDLE && i_valid) begin
                addr_r  <= i_result;
                sdata_r <= i_store_data;
                rd_en_r <= i_mem_read;
                wr_en_r <= i_mem_write;
                f3_r    <= i_funct3;
                rd_r    <= i_rd;
            end
            if (state_r == ACCESS && !illegal_s && !wr_en_r) begin
                wb_data_r <= rd_en_r ? load_extend(mem_r[idx_s], off_s, f3_r) : addr_r;
                wb_rd_r   <= rd_r;
            end
        end
    end

    // Store lanes; a reset on the ACCESS edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && state_r == ACCESS && wr_en_r && !illegal_s) begin
            for (int i = 0; i < NB; i++) begin
                if (be_s[i]) mem_r[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
            end
        end
    end

    assign o_ready    = ready_r;
    assign o_wb_valid = wb_valid_r;
    assign o_wb_data  = wb_data_r;
    assign o_wb_rd    = wb_rd_r;
    assign o_flush    = flush_r;
    assign o_err      = err_r;
endmodule

// File: tb/tb_data_mem_stage.sv
// Directed scoreboard bench for data_mem_stage: each request pushes its
// expected outcome, which is popped and checked when the stage responds.
module tb_data_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, o_ready;
    logic [31:0] i_result, i_store_data;
    logic        i_mem_read, i_mem_write;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd;
    logic        o_wb_valid, i_wb_ready;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd;
    logic        o_flush, o_err;

    typedef struct {
        logic        wb;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    data_mem_stage dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_result(i_result), .i_store_data(i_store_data),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_funct3(i_funct3), .i_rd(i_rd), .o_wb_valid(o_wb_valid),
        .i_wb_ready(i_wb_ready), .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd),
        .o_flush(o_flush), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the stage idle; returns at a negedge with it idle again.
    task automatic run_req(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rdi,
                           input int stall, input logic exp_wb, input logic [31:0] exp_data,
                           input logic exp_err);
        exp_t e;
        exp_t got;
        e.wb = exp_wb; e.data = exp_data; e.rd = rdi; e.err = exp_err;
        sb_q.push_back(e);
        check({tag, ":ready_idle"}, 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr; i_funct3 = f3;
        i_result = addr; i_store_data = sdata; i_rd = rdi;
        i_wb_ready = (stall == 0);
        @(negedge clk);
        i_valid = 1'b0;
        i_result = $urandom; i_store_data = $urandom; i_rd = 5'($urandom);
        check({tag, ":ready_busy"}, 32'(o_ready), 32'd0);
        @(negedge clk);
        got = sb_q.pop_front();
        if (got.wb) begin
            check({tag, ":wb_valid"}, 32'(o_wb_valid), 32'd1);
            check({tag, ":wb_data"}, o_wb_data, got.data);
            check({tag, ":wb_rd"}, 32'(o_wb_rd), 32'(got.rd));
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check({tag, ":stall_valid"}, 32'(o_wb_valid), 32'd1);
                check({tag, ":stall_data"}, o_wb_data, got.data);
                check({tag, ":stall_ready"}, 32'(o_ready), 32'd0);
                check({tag, ":stall_flush"}, 32'(o_flush), 32'd0);
            end
            i_wb_ready = 1'b1;
            @(negedge clk);
        end
        check({tag, ":no_wb_at_retire"}, 32'(o_wb_valid), 32'd0);
        check({tag, ":flush"}, 32'(o_flush), 32'd1);
        check({tag, ":err"}, 32'(o_err), 32'(got.err));
        i_wb_ready = 1'b1;
        @(negedge clk);
        check({tag, ":flush_done"}, 32'(o_flush), 32'd0);
        check({tag, ":err_done"}, 32'(o_err), 32'd0);
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_result = 32'd0; i_store_data = 32'd0;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_funct3 = 3'd0; i_rd = 5'd0; i_wb_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst:ready", 32'(o_ready), 32'd1);
        check("rst:wb_valid", 32'(o_wb_valid), 32'd0);
        check("rst:flush", 32'(o_flush), 32'd0);
        check("rst:err", 32'(o_err), 32'd0);
        check("rst:wb_data", o_wb_data, 32'd0);
        check("rst:wb_rd", 32'(o_wb_rd), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_req("sw8",   1'b0, 1'b1, 3'b010, 32'h8,  32'hDEADBEEF, 5'd0, 0, 1'b0, 32'h0, 1'b0);
        run_req("lw8",   1'b1, 1'b0, 3'b010, 32'h8,  32'h0, 5'd5,  0, 1'b1, 32'hDEADBEEF, 1'b0);
        run_req("sb9",   1'b0, 1'b1, 3'b000, 32'h9,  32'hABCDEF80, 5'd0, 0, 1'b0, 32'h0, 1'b0);
        run_req("lb9",   1'b1, 1'b0, 3'b000, 32'h9,  32'h0, 5'd6,  0, 1'b1, 32'hFFFFFF80, 1'b0);
        run_req("lbu9",  1'b1, 1'b0, 3'b100, 32'h9,  32'h0, 5'd7,  0, 1'b1, 32'h00000080, 1'b0);
        run_req("lw8b",  1'b1, 1'b0, 3'b010, 32'h8,  32'h0, 5'd8,  0, 1'b1, 32'hDEAD80EF, 1'b0);
        run_req("lw6",   1'b1, 1'b0, 3'b010, 32'h6,  32'h0, 5'd9,  0, 1'b0, 32'h0, 1'b1);
        run_req("lw4",   1'b1, 1'b0, 3'b010, 32'h4,  32'h0, 5'd9,  0, 1'b1, 32'h0, 1'b0);
        run_req("lw88",  1'b1, 1'b0, 3'b010, 32'h88, 32'h0, 5'd4,  0, 1'b1, 32'hDEAD80EF, 1'b0);
        run_req("stall", 1'b1, 1'b0, 3'b010, 32'h8,  32'h0, 5'd10, 5, 1'b1, 32'hDEAD80EF, 1'b0);
        run_req("shA",   1'b0, 1'b1, 3'b001, 32'hA,  32'h1234CAFE, 5'd0, 0, 1'b0, 32'h0, 1'b0);
        run_req("lhA",   1'b1, 1'b0, 3'b001, 32'hA,  32'h0, 5'd11, 0, 1'b1, 32'hFFFFCAFE, 1'b0);
        run_req("lhuA",  1'b1, 1'b0, 3'b101, 32'hA,  32'h0, 5'd11, 0, 1'b1, 32'h0000CAFE, 1'b0);
        run_req("lw8c",  1'b1, 1'b0, 3'b010, 32'h8,  32'h0, 5'd1,  0, 1'b1, 32'hCAFE80EF, 1'b0);
        run_req("alu",   1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd12, 0, 1'b1, 32'h1234, 1'b0);
        run_req("alu_r0", 1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd0, 0, 1'b0, 32'h0, 1'b0);
        run_req("lw_r0", 1'b1, 1'b0, 3'b010, 32'h8,  32'h0, 5'd0,  0, 1'b0, 32'h0, 1'b0);
        run_req("sh9",   1'b0, 1'b1, 3'b001, 32'h9,  32'hFFFF, 5'd0, 0, 1'b0, 32'h0, 1'b1);
        run_req("rdwr",  1'b1, 1'b1, 3'b010, 32'h8,  32'h0, 5'd2,  0, 1'b0, 32'h0, 1'b1);
        run_req("f3bad", 1'b1, 1'b0, 3'b011, 32'h8,  32'h0, 5'd2,  0, 1'b0, 32'h0, 1'b1);
        run_req("lw8d",  1'b1, 1'b0, 3'b010, 32'h8,  32'h0, 5'd3,  0, 1'b1, 32'hCAFE80EF, 1'b0);

        // Reset lands on the ACCESS edge of a store: no write, stage idle again.
        check("rstacc:ready_idle", 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b1; i_funct3 = 3'b010;
        i_result = 32'h0; i_store_data = 32'h12345678; i_rd = 5'd0;
        @(negedge clk);
        i_valid = 1'b0;
        check("rstacc:in_access", 32'(o_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstacc:ready", 32'(o_ready), 32'd1);
        check("rstacc:flush", 32'(o_flush), 32'd0);
        check("rstacc:wb_valid", 32'(o_wb_valid), 32'd0);
        run_req("lw0",   1'b1, 1'b0, 3'b010, 32'h0,  32'h0, 5'd3,  0, 1'b1, 32'h0, 1'b0);
        run_req("lw8e",  1'b1, 1'b0, 3'b010, 32'h8,  32'h0, 5'd3,  0, 1'b1, 32'hCAFE80EF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
